// File: rtl/nf10_cutter_input_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_cutter_arb_defs (package)
//  Description : Shared definitions for the cutter input arbiter: port count,
//                FSM state encoding and the round-robin selection helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package nf10_cutter_arb_defs;

    localparam int NUM_PORTS = 5;

    // Last-granted index after reset; port 0 is therefore scanned first
    localparam logic [2:0] LAST_GRANT_RST = 3'd4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Scan last+1, last+2, ... (mod NUM_PORTS) and return the first requester one-hot
    function automatic logic [NUM_PORTS-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [2:0]           last
    );
        logic [NUM_PORTS-1:0] gnt;
        logic [2:0]           idx;
        gnt = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = 3'((int'(last) + i) % NUM_PORTS);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

    // One-hot to binary index (lowest set bit wins; input is one-hot in practice)
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_axis_skid_2.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_axis_skid_2
//  Description : Two-entry AXI-Stream register slice. Entry 0 drives the
//                output, entry 1 absorbs the beat accepted while the output
//                stalls. Input ready is registered (entry 1 empty), so no
//                combinational path runs from out_ready_i to in_ready_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_axis_skid_2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    logic [DATA_W-1:0] e0_data_q, e0_data_d;
    logic [DATA_W-1:0] e1_data_q, e1_data_d;
    logic              e0_valid_q, e0_valid_d;
    logic              e1_valid_q, e1_valid_d;
    logic              w_push;
    logic              w_pop;

    assign in_ready_o  = !e1_valid_q;
    assign out_valid_o = e0_valid_q;
    assign out_data_o  = e0_data_q;
    assign w_push      = in_valid_i && !e1_valid_q;
    assign w_pop       = e0_valid_q && out_ready_i;

    // Next-state: refill entry 0 from entry 1 first, otherwise from the input
    always_comb begin
        e0_data_d  = e0_data_q;
        e1_data_d  = e1_data_q;
        e0_valid_d = e0_valid_q;
        e1_valid_d = e1_valid_q;
        if (e1_valid_q) begin
            if (w_pop) begin
                e0_data_d  = e1_data_q;
                e1_valid_d = 1'b0;
            end
        end else if (!e0_valid_q || w_pop) begin
            e0_valid_d = w_push;
            if (w_push) begin
                e0_data_d = in_data_i;
            end
        end else if (w_push) begin
            e1_valid_d = 1'b1;
            e1_data_d  = in_data_i;
        end
    end

    // Storage registers; reset empties both entries and clears the data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e0_data_q  <= '0;
            e1_data_q  <= '0;
            e0_valid_q <= 1'b0;
            e1_valid_q <= 1'b0;
        end else begin
            e0_data_q  <= e0_data_d;
            e1_data_q  <= e1_data_d;
            e0_valid_q <= e0_valid_d;
            e1_valid_q <= e1_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nf10_cutter_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_cutter_input_arbiter
//  Description : Packet-granular round-robin arbiter sharing one packet cutter
//                between five AXI-Stream inputs. A port stays locked from its
//                first beat through TLAST; the output goes through a 2-entry
//                register slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_cutter_input_arbiter
    import nf10_cutter_arb_defs::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                            s_axis_tvalid_0,
    input  logic                            s_axis_tlast_0,
    output logic                            s_axis_tready_0,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                            s_axis_tvalid_1,
    input  logic                            s_axis_tlast_1,
    output logic                            s_axis_tready_1,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic                            s_axis_tvalid_2,
    input  logic                            s_axis_tlast_2,
    output logic                            s_axis_tready_2,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic                            s_axis_tvalid_3,
    input  logic                            s_axis_tlast_3,
    output logic                            s_axis_tready_3,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
    input  logic                            s_axis_tvalid_4,
    input  logic                            s_axis_tlast_4,
    output logic                            s_axis_tready_4,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,

    output logic [NUM_PORTS-1:0]            grant
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int BEAT_W = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;

    logic [C_AXIS_DATA_WIDTH-1:0]  w_tdata [NUM_PORTS];
    logic [STRB_W-1:0]             w_tstrb [NUM_PORTS];
    logic [C_AXIS_TUSER_WIDTH-1:0] w_tuser [NUM_PORTS];
    logic [NUM_PORTS-1:0]          w_tvalid;
    logic [NUM_PORTS-1:0]          w_tlast;
    logic [NUM_PORTS-1:0]          w_tready;

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0] w_pick;

    logic [BEAT_W-1:0]    w_sel_beat;
    logic                 w_sel_valid;
    logic                 w_locked;
    logic                 w_skid_in_valid;
    logic                 w_skid_in_ready;
    logic                 w_xfer;
    logic [BEAT_W-1:0]    w_skid_out;

    assign w_tdata[0] = s_axis_tdata_0;
    assign w_tdata[1] = s_axis_tdata_1;
    assign w_tdata[2] = s_axis_tdata_2;
    assign w_tdata[3] = s_axis_tdata_3;
    assign w_tdata[4] = s_axis_tdata_4;
    assign w_tstrb[0] = s_axis_tstrb_0;
    assign w_tstrb[1] = s_axis_tstrb_1;
    assign w_tstrb[2] = s_axis_tstrb_2;
    assign w_tstrb[3] = s_axis_tstrb_3;
    assign w_tstrb[4] = s_axis_tstrb_4;
    assign w_tuser[0] = s_axis_tuser_0;
    assign w_tuser[1] = s_axis_tuser_1;
    assign w_tuser[2] = s_axis_tuser_2;
    assign w_tuser[3] = s_axis_tuser_3;
    assign w_tuser[4] = s_axis_tuser_4;
    assign w_tvalid   = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                         s_axis_tvalid_1, s_axis_tvalid_0};
    assign w_tlast    = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2,
                         s_axis_tlast_1, s_axis_tlast_0};

    assign s_axis_tready_0 = w_tready[0];
    assign s_axis_tready_1 = w_tready[1];
    assign s_axis_tready_2 = w_tready[2];
    assign s_axis_tready_3 = w_tready[3];
    assign s_axis_tready_4 = w_tready[4];

    assign grant    = grant_q;
    assign w_locked = (state_q == LOCKED);
    assign w_pick   = rr_pick(w_tvalid, last_grant_q);

    // Only the locked port may see ready; all others hold off until the next IDLE
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_tready
            assign w_tready[p] = w_locked && grant_q[p] && w_skid_in_ready;
        end
    endgenerate

    // AND-OR mux of the granted port's beat; grant is zero while idle
    always_comb begin
        w_sel_beat = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q[p]) begin
                w_sel_beat = {w_tdata[p], w_tstrb[p], w_tuser[p], w_tlast[p]};
            end
        end
    end

    assign w_sel_valid     = |(w_tvalid & grant_q);
    assign w_skid_in_valid = w_locked && w_sel_valid;
    assign w_xfer          = w_skid_in_valid && w_skid_in_ready;

    // Next-state: pick a requester while idle, release the lock on the TLAST beat
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|w_tvalid) begin
                    grant_d      = w_pick;
                    last_grant_d = onehot_to_idx(w_pick);
                    state_d      = LOCKED;
                end
            end
            LOCKED: begin
                if (w_xfer && w_sel_beat[0]) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    nf10_axis_skid_2 #(
        .DATA_W (BEAT_W)
    ) u_skid (
        .clk_i       (axi_aclk),
        .rst_n_i     (axi_resetn),
        .in_data_i   (w_sel_beat),
        .in_valid_i  (w_skid_in_valid),
        .in_ready_o  (w_skid_in_ready),
        .out_data_o  (w_skid_out),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = w_skid_out;

endmodule
`default_nettype wire

// File: tb/tb_nf10_cutter_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf10_cutter_input_arbiter
//  Description : Directed self-checking bench for the cutter input arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf10_cutter_input_arbiter;

    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_tdata [5];
    logic [SW-1:0] s_tstrb [5];
    logic [UW-1:0] s_tuser [5];
    logic [4:0]    s_tvalid;
    logic [4:0]    s_tlast;
    logic [4:0]    s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [4:0]    grant;

    beat_t      mem [5][16];
    int         cnt [5];
    int         ptr [5];
    logic [4:0] en;
    beat_t      out_q[$];
    int         out_cyc[$];
    int         cyc;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    nf10_cutter_input_arbiter dut (
        .axi_aclk        (clk),
        .axi_resetn      (rstn),
        .s_axis_tdata_0  (s_tdata[0]), .s_axis_tstrb_0 (s_tstrb[0]), .s_axis_tuser_0 (s_tuser[0]),
        .s_axis_tvalid_0 (s_tvalid[0]), .s_axis_tlast_0 (s_tlast[0]), .s_axis_tready_0 (s_tready[0]),
        .s_axis_tdata_1  (s_tdata[1]), .s_axis_tstrb_1 (s_tstrb[1]), .s_axis_tuser_1 (s_tuser[1]),
        .s_axis_tvalid_1 (s_tvalid[1]), .s_axis_tlast_1 (s_tlast[1]), .s_axis_tready_1 (s_tready[1]),
        .s_axis_tdata_2  (s_tdata[2]), .s_axis_tstrb_2 (s_tstrb[2]), .s_axis_tuser_2 (s_tuser[2]),
        .s_axis_tvalid_2 (s_tvalid[2]), .s_axis_tlast_2 (s_tlast[2]), .s_axis_tready_2 (s_tready[2]),
        .s_axis_tdata_3  (s_tdata[3]), .s_axis_tstrb_3 (s_tstrb[3]), .s_axis_tuser_3 (s_tuser[3]),
        .s_axis_tvalid_3 (s_tvalid[3]), .s_axis_tlast_3 (s_tlast[3]), .s_axis_tready_3 (s_tready[3]),
        .s_axis_tdata_4  (s_tdata[4]), .s_axis_tstrb_4 (s_tstrb[4]), .s_axis_tuser_4 (s_tuser[4]),
        .s_axis_tvalid_4 (s_tvalid[4]), .s_axis_tlast_4 (s_tlast[4]), .s_axis_tready_4 (s_tready[4]),
        .m_axis_tdata    (m_tdata),
        .m_axis_tstrb    (m_tstrb),
        .m_axis_tuser    (m_tuser),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tready   (m_tready),
        .grant           (grant)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkd(input int p, input int k, input int b);
        return {8{8'(p), 8'(k), 8'(b), 8'hA5}};
    endfunction

    function automatic logic [UW-1:0] mku(input int p, input int nb);
        return {96'h0, 8'h00, 8'(1 << p), 16'(nb * 32)};
    endfunction

    task automatic drive_all();
        for (int p = 0; p < 5; p++) begin
            if (en[p] && ptr[p] < cnt[p]) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p]  = mem[p][ptr[p]].d;
                s_tstrb[p]  = mem[p][ptr[p]].s;
                s_tuser[p]  = mem[p][ptr[p]].u;
                s_tlast[p]  = mem[p][ptr[p]].l;
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p]  = '0;
                s_tstrb[p]  = '0;
                s_tuser[p]  = '0;
                s_tlast[p]  = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < 5; p++) begin
            cnt[p] = 0;
            ptr[p] = 0;
        end
        en = '0;
        drive_all();
    endtask

    task automatic load_pkt(input int p, input int k, input int nb);
        for (int b = 0; b < nb; b++) begin
            mem[p][cnt[p]].d = mkd(p, k, b);
            mem[p][cnt[p]].s = (b == nb - 1) ? 32'h0000_ffff : 32'hffff_ffff;
            mem[p][cnt[p]].u = mku(p, nb);
            mem[p][cnt[p]].l = (b == nb - 1);
            cnt[p]++;
        end
    endtask

    task automatic wait_out(input int n, input string tag);
        for (int i = 0; i < 200 && out_q.size() < n; i++) @(negedge clk);
        chk(tag, 256'(out_q.size()), 256'(n));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_src();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        out_q.delete();
        out_cyc.delete();
    endtask

    // Source driver: advance each port past a beat seen accepted at the last edge
    initial begin
        logic [4:0] xfer;
        forever begin
            @(negedge clk);
            xfer = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < 5; p++) if (xfer[p]) ptr[p]++;
            drive_all();
        end
    end

    // Output monitor: log every beat that the next edge transfers
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_tvalid && m_tready) begin
                out_q.push_back('{d: m_tdata, s: m_tstrb, u: m_tuser, l: m_tlast});
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_tready = 1'b1;
        do_reset();

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_grant",  256'(grant), 256'(0));
        chk("rst_mvalid", 256'(m_tvalid), 256'(0));
        chk("rst_mlast",  256'(m_tlast), 256'(0));
        chk("rst_mdata",  m_tdata, 256'(0));
        chk("rst_muser",  256'(m_tuser), 256'(0));
        chk("rst_sready", 256'(s_tready), 256'(0));

        // ---------------- T1: single 3-beat packet on port 2 ----------------
        @(posedge clk); #2;
        for (int b = 0; b < 3; b++) begin
            mem[2][b].d = {32{8'(b)}};
            mem[2][b].s = 32'hffff_ffff;
            mem[2][b].u = mku(2, 3);
            mem[2][b].l = (b == 2);
        end
        cnt[2] = 3;
        en[2]  = 1'b1;
        drive_all();
        @(negedge clk);
        chk("t1_grant_pre", 256'(grant), 256'(0));
        @(negedge clk);
        chk("t1_grant", 256'(grant), 256'(5'b00100));
        chk("t1_mvalid_early", 256'(m_tvalid), 256'(0));
        chk("t1_sready", 256'(s_tready), 256'(5'b00100));
        @(negedge clk);
        chk("t1_mvalid", 256'(m_tvalid), 256'(1));
        chk("t1_mdata0", m_tdata, {32{8'h00}});
        wait_out(3, "t1_count");
        chk("t1_b1", out_q[1].d, {32{8'h01}});
        chk("t1_b2", out_q[2].d, {32{8'h02}});
        chk("t1_user", 256'(out_q[0].u), 256'(mku(2, 3)));
        chk("t1_last0", 256'(out_q[0].l), 256'(0));
        chk("t1_last2", 256'(out_q[2].l), 256'(1));
        chk("t1_grant_end", 256'(grant), 256'(0));

        // ---------------- T2: all ports, round-robin order and gaps ----------------
        do_reset();
        @(posedge clk); #2;
        for (int p = 0; p < 5; p++) load_pkt(p, 0, 2);
        load_pkt(0, 1, 2);
        en = 5'h1f;
        drive_all();
        wait_out(12, "t2_count");
        begin
            int ports [6] = '{0, 1, 2, 3, 4, 0};
            int pkts  [6] = '{0, 0, 0, 0, 0, 1};
            for (int i = 0; i < 6; i++) begin
                chk("t2_src", 256'(out_q[2*i].u[23:16]), 256'(8'(1 << ports[i])));
                chk("t2_d0", out_q[2*i].d, mkd(ports[i], pkts[i], 0));
                chk("t2_d1", out_q[2*i+1].d, mkd(ports[i], pkts[i], 1));
                chk("t2_last", 256'({out_q[2*i].l, out_q[2*i+1].l}), 256'(2'b01));
                if (i > 0) chk("t2_gap", 256'(out_cyc[2*i] - out_cyc[2*i-2]), 256'(3));
            end
        end
        chk("t2_strb_last", 256'(out_q[1].s), 256'(32'h0000_ffff));

        // ---------------- T3: late request and mid-packet stall on port 0 ----------------
        @(posedge clk); #2;
        clear_src();
        out_q.delete();
        load_pkt(0, 2, 4);
        load_pkt(3, 0, 1);
        en = 5'b00001;
        drive_all();
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        en = 5'b01000;
        drive_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_grant", 256'(grant), 256'(5'b00001));
            chk("t3_ready3", 256'(s_tready[3]), 256'(0));
        end
        @(posedge clk); #2;
        en = 5'b01001;
        drive_all();
        for (int i = 0; i < 50 && grant != 5'b01000; i++) @(negedge clk);
        chk("t3_grant3", 256'(grant), 256'(5'b01000));
        wait_out(5, "t3_count");
        for (int b = 0; b < 4; b++) chk("t3_p0", out_q[b].d, mkd(0, 2, b));
        chk("t3_p3", out_q[4].d, mkd(3, 0, 0));

        // ---------------- T4: output backpressure 1,0,0,1 ----------------
        @(posedge clk); #2;
        clear_src();
        out_q.delete();
        m_tready = 1'b1;
        load_pkt(1, 0, 4);
        en = 5'b00010;
        drive_all();
        for (int i = 0; i < 50 && !m_tvalid; i++) @(negedge clk);
        chk("t4_mvalid", 256'(m_tvalid), 256'(1));
        chk("t4_d0", m_tdata, mkd(1, 0, 0));
        @(posedge clk); #2 m_tready = 1'b0;
        @(negedge clk);
        chk("t4_stall1_d", m_tdata, mkd(1, 0, 1));
        chk("t4_stall1_rdy", 256'(s_tready[1]), 256'(1));
        @(posedge clk); #2 m_tready = 1'b0;
        @(negedge clk);
        chk("t4_stall2_d", m_tdata, mkd(1, 0, 1));
        chk("t4_stall2_v", 256'(m_tvalid), 256'(1));
        chk("t4_full_rdy", 256'(s_tready[1]), 256'(0));
        @(posedge clk); #2 m_tready = 1'b1;
        @(negedge clk);
        chk("t4_resume_d", m_tdata, mkd(1, 0, 1));
        chk("t4_resume_rdy", 256'(s_tready[1]), 256'(0));
        wait_out(4, "t4_count");
        repeat (5) @(negedge clk);
        chk("t4_no_dup", 256'(out_q.size()), 256'(4));
        for (int b = 0; b < 4; b++) chk("t4_seq", out_q[b].d, mkd(1, 0, b));

        // ---------------- T5: asynchronous reset mid-packet ----------------
        @(posedge clk); #2;
        clear_src();
        out_q.delete();
        load_pkt(3, 0, 4);
        en = 5'b01000;
        drive_all();
        wait_out(2, "t5_pre");
        @(posedge clk); #3 rstn = 1'b0;
        #1;
        chk("t5_mvalid_rst", 256'(m_tvalid), 256'(0));
        chk("t5_grant_rst", 256'(grant), 256'(0));
        chk("t5_sready_rst", 256'(s_tready), 256'(0));
        clear_src();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        out_q.delete();
        out_cyc.delete();
        @(posedge clk); #2;
        load_pkt(1, 5, 1);
        load_pkt(4, 5, 1);
        en = 5'b10010;
        drive_all();
        for (int i = 0; i < 20 && grant == 5'b00000; i++) @(negedge clk);
        chk("t5_first_grant", 256'(grant), 256'(5'b00010));
        wait_out(2, "t5_count");
        chk("t5_b0", out_q[0].d, mkd(1, 5, 0));
        chk("t5_b0_last", 256'(out_q[0].l), 256'(1));
        chk("t5_b1", out_q[1].d, mkd(4, 5, 0));
        repeat (5) @(negedge clk);
        chk("t5_no_stale", 256'(out_q.size()), 256'(2));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nf10_cutter_input_arbiter.md
Name: nf10_cutter_input_arbiter

Overview:
Packet-granular round-robin arbiter that shares one nf10_packet_cutter datapath between five AXI4-Stream input ports.
It locks onto one input for the whole packet (first beat through TLAST), so packets are never interleaved.
It drives the cutter's S_AXIS through a registered skid stage to keep the 200 MHz path closed.
It sits between the per-port input queues and the cutter; the cutter output feeds nf10_bram_output_queues as before.

Parameters:
C_AXIS_DATA_WIDTH, 256, TDATA width on all ports
C_AXIS_TUSER_WIDTH, 128, TUSER width on all ports (NetFPGA metadata: [15:0] length, [23:16] src port, [31:24] dst port)
NUM_PORTS, 5, number of inputs; fixed at 5, and the port list is written out explicitly

Ports:
axi_aclk  in  1  single clock
axi_resetn  in  1  reset, asynchronous, active-low
s_axis_tdata_i  in  C_AXIS_DATA_WIDTH  input i data (i = 0..4, one port set per input)
s_axis_tstrb_i  in  C_AXIS_DATA_WIDTH/8  input i byte strobes
s_axis_tuser_i  in  C_AXIS_TUSER_WIDTH  input i metadata; only valid on the first beat
s_axis_tvalid_i  in  1  input i valid
s_axis_tlast_i  in  1  input i last beat
s_axis_tready_i  out  1  input i ready
m_axis_tdata  out  C_AXIS_DATA_WIDTH  to cutter S_AXIS_TDATA
m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  to cutter S_AXIS_TSTRB
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  to cutter S_AXIS_TUSER
m_axis_tvalid  out  1  to cutter S_AXIS_TVALID
m_axis_tlast  out  1  to cutter S_AXIS_TLAST
m_axis_tready  in  1  from cutter S_AXIS_TREADY
grant  out  5  one-hot port currently locked; 0 when idle (debug/stats)

Behaviour:
- Reset (axi_resetn = 0, asynchronous):
  - FSM goes to IDLE; last_grant = 4, so port 0 has highest priority after reset.
  - grant = 0; all s_axis_tready_i = 0.
  - Skid stage emptied; m_axis_tvalid = 0; m_axis_tlast = 0.
  - Data/user/strb outputs = 0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - All s_axis_tready_i = 0.
  - If any s_axis_tvalid_i is high, select the first requester scanning last_grant+1, +2, ... modulo 5.
  - Register the selection into grant and last_grant; next state LOCKED.
  - If no requester, stay in IDLE.
- LOCKED:
  - s_axis_tready_g = skid input ready, where g is the granted port; every other tready stays 0.
  - A beat transfers when tvalid_g && tready_g.
  - A transfer with tlast_g = 1 moves the FSM to IDLE next cycle and clears grant.
- Packet gap: exactly one bubble cycle (the IDLE decision cycle) separates consecutive packets on the input side. With continuous requests, throughput is N/(N+1) for N-beat packets.
- Skid stage: 2 entries.
  - Input ready = entry 1 empty.
  - Latency is 1 cycle from input accept to m_axis_tvalid.
  - Full throughput when m_axis_tready is held high.
  - Holds data stable while m_axis_tvalid && !m_axis_tready (AXIS rule: valid never drops without a transfer).
- Fairness: a port granted in packet k has lowest priority for packet k+1. With all 5 ports requesting, the grant order is 0, 1, 2, 3, 4, 0, ...
- A port dropping tvalid mid-packet keeps the lock. The arbiter waits indefinitely; there is no timeout.
- Simultaneous events:
  - A tvalid rising on another port during LOCKED is ignored until IDLE.
  - The tlast beat and a new request on the same cycle: the new request is arbitrated in the following IDLE cycle.
- TUSER/TSTRB/TDATA pass through unmodified.
- Reset mid-packet: the partial packet is discarded; no TLAST is synthesized. The upstream must also be reset, since the cutter shares axi_resetn.

Decomposition:
- Shared package/include nf10_cutter_arb_defs:
  - FSM state localparams (IDLE = 0, LOCKED = 1).
  - NUM_PORTS = 5.
  - Round-robin rotate/priority-encode function (5-bit request, 3-bit last grant -> one-hot grant).
- One sub-module, nf10_axis_skid_2: the 2-entry register slice with parameterised data width. It carries {tdata, tstrb, tuser, tlast}.

Test Plan:
1. Reset, then port 2 sends 3 beats (tdata = {32{8'h00}}, {32{8'h01}}, {32{8'h02}}), m_axis_tready = 1 -> grant = 5'b00100 one cycle later; m_axis beats identical and in order; first m_axis_tvalid 2 cycles after tvalid_2 rises; grant returns to 0 after tlast.
2. All 5 ports continuously offer 2-beat packets with tuser[23:16] = one-hot port -> output packet order by src port is 0x01, 0x02, 0x04, 0x08, 0x10, 0x01; no interleaving; exactly 1 idle input cycle between packets.
3. Port 0 streaming; port 3 asserts tvalid mid-packet of port 0 -> port 3 tready stays 0 until port 0's tlast; next grant = 5'b01000.
4. m_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; m_axis_tdata stable while stalled; the granted tready deasserts when the skid holds 2 entries.
5. Assert axi_resetn = 0 asynchronously during beat 2 of 4, then release; port 1 sends 1 beat -> m_axis_tvalid = 0 immediately on reset; after release, first grant goes to port 1 (priority from port 0, port 0 idle); the output shows only the new beat.
6. Integrated with nf10_packet_cutter: program cut bytes = 0x3f, offset = 0xfffffffe, word = 0, enable = 1; send a 4-beat packet on port 4 -> cutter output carries a truncated packet with tlast asserted, and output queue tvalid_4 follows.
